uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver. It supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits. Each bit is resolved by a 3-sample majority vote, and the block reports parity error, framing error and line break alongside each received word. It sits between the FPGA RX pin and the host-side byte consumer, running in the system clock domain.

Parameters:
CLKS_PER_BIT, 868, system clock cycles per UART bit; must be >= 4.
DATA_BITS, 8, data bits per frame; legal range 5..9; LSB received first.
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
i_Clock  input  1  system clock; all logic on rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Rx_Serial  input  1  asynchronous serial line; idles high.
o_Rx_DV  output  1  one-cycle pulse: word and status valid.
o_Rx_Byte  output  DATA_BITS  last received word; held until the next frame completes.
o_Parity_Err  output  1  parity mismatch; valid with o_Rx_DV.
o_Frame_Err  output  1  a stop bit sampled 0; valid with o_Rx_DV.
o_Break  output  1  break frame received; valid with o_Rx_DV.
o_Busy  output  1  high in every state except IDLE.

Behaviour:
- Synchroniser: i_Rx_Serial passes through a 2-flop synchroniser; both flops reset to 1. A 3-bit history register of the synchronised line also resets to 3'b111.
- Vote: V = majority of the 3 most recent synchronised samples. V is evaluated only at sample points.
- Bit counter: width clog2(CLKS_PER_BIT). HALF = (CLKS_PER_BIT-1)/2.
- Reset: state IDLE; counters 0; o_Rx_Byte 0; o_Rx_DV, o_Parity_Err, o_Frame_Err, o_Break 0. Reset asserted mid-frame aborts the frame with no DV pulse.
- States and transitions:
  - IDLE: counter 0. Synchronised line 0 -> START.
  - START: count to HALF. At HALF, V=1 -> IDLE (false start, no DV); V=0 -> counter 0, DATA.
  - DATA: sample at count CLKS_PER_BIT-1, shifting V into bit index 0..DATA_BITS-1. After the last bit: PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: sample at CLKS_PER_BIT-1. Expected value = XOR of data bits (even) or its inverse (odd). Mismatch latches a parity error.
  - STOP: sample STOP_BITS bits, each at CLKS_PER_BIT-1. Any V=0 latches a framing error. After the last stop sample -> DONE.
  - DONE: one cycle. o_Rx_DV=1; o_Rx_Byte updated; status outputs driven.
    - No framing error -> IDLE.
    - Framing error -> WAIT_HIGH.
  - WAIT_HIGH: stay until synchronised line is 1, then -> IDLE. This prevents retriggering during a break.
- Output timing:
  - o_Rx_DV is 1 for exactly one cycle per completed frame; 0 on false starts.
  - Status flags are registered with o_Rx_Byte and are 0 except in the DV cycle.
- Break: o_Break=1 when all data bits, the parity bit (if present) and the first stop bit all sampled 0. o_Frame_Err is also 1 in that case.
- Parity error is reported even when a framing error occurs. The received word is still delivered on errors.
- Latency: from the IDLE start-detect cycle to the DV cycle = (HALF+1) + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT + 1 cycles, where P = 1 if parity is enabled, else 0.
- A new start edge is accepted in the cycle after DONE when the line has already returned to idle.

Test Plan:
1. CLKS_PER_BIT=16, 8N1; send 0xA5 -> single DV pulse, o_Rx_Byte=0xA5, all error flags 0, o_Busy low after DONE.
2. PARITY_MODE=2; send 0x37 with parity bit 1 -> no error. Resend with parity bit 0 -> o_Parity_Err=1, o_Rx_Byte=0x37.
3. Hold line low for 20 bit times, then release -> exactly one DV with o_Rx_Byte=0x00, o_Frame_Err=1, o_Break=1. No further DV until the line is high, then an 0x5A frame is received cleanly.
4. Noise: 3-cycle low glitch on an idle line -> false start, no DV. A 1-cycle inverted glitch at a data-bit sample point -> word unaffected (0xC3 received).
5. DATA_BITS=7, STOP_BITS=2, PARITY_MODE=1; send 0x55 back-to-back twice -> two DV pulses, both 0x55, no errors. Second stop bit 0 -> o_Frame_Err=1, o_Break=0.
6. Assert i_Reset mid-DATA of a frame -> no DV, all outputs 0. The next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle: asynchronous serial line in, received word and frame status out.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Break;
  logic                 o_Busy;

  // master drives the line and consumes words; slave is the receiver
  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
  );

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV, o_Rx_Byte, o_Parity_Err, o_Frame_Err, o_Break, o_Busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity, 1/2 stop) with 3-sample majority vote.
// DV arrives (HALF+1)+(bits after start)*CLKS_PER_BIT+1 cycles after start detect; no backpressure, one-cycle DV pulse.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  uart_rx_cfg_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_WAIT_HIGH
  } state_t;

  state_t state, state_nxt;

  logic                 rx_meta, rx_sync;
  logic [2:0]           hist;
  logic                 vote;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err, frm_err, all_zero;
  logic                 bit_tick, exp_par;
  logic                 done_load, fe_final, brk_final, busy;

  logic                 rx_dv_q;
  logic [DATA_BITS-1:0] rx_byte_q;
  logic                 par_err_q, frm_err_q, brk_q;

  assign vote     = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign bit_tick = (cnt == LAST_CNT);
  assign exp_par  = (PARITY_MODE == 1) ? ~(^shift_reg) : (^shift_reg);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (!rx_sync) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == HALF) state_nxt = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_tick && (bit_idx == LAST_BIT))
          state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_tick) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_tick && (stop_idx == STOP_LAST)) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = frm_err ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: begin
        if (rx_sync) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The final stop sample is folded in here because frm_err/all_zero only catch up one cycle later.
  always_comb begin
    busy      = (state != S_IDLE);
    done_load = (state == S_STOP) && (state_nxt == S_DONE);
    fe_final  = frm_err | ~vote;
    brk_final = all_zero & (stop_idx | ~vote);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      hist      <= 3'b111;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      all_zero  <= 1'b1;
      rx_dv_q   <= 1'b0;
      rx_byte_q <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      rx_meta <= bus.i_Rx_Serial;
      rx_sync <= rx_meta;
      hist    <= {hist[1:0], rx_sync};

      unique case (state)
        S_IDLE: begin
          cnt      <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          par_err  <= 1'b0;
          frm_err  <= 1'b0;
          all_zero <= 1'b1;
        end
        S_START: begin
          cnt <= (cnt == HALF) ? '0 : cnt + 1'b1;
        end
        S_DATA, S_PARITY, S_STOP: begin
          cnt <= bit_tick ? '0 : cnt + 1'b1;
          if (bit_tick) begin
            if (state == S_DATA) begin
              shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
              bit_idx   <= bit_idx + 1'b1;
              if (vote) all_zero <= 1'b0;
            end else if (state == S_PARITY) begin
              par_err <= (vote != exp_par);
              if (vote) all_zero <= 1'b0;
            end else begin
              if (!vote) frm_err <= 1'b1;
              if (vote && !stop_idx) all_zero <= 1'b0;
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase

      rx_dv_q   <= done_load;
      par_err_q <= done_load & par_err;
      frm_err_q <= done_load & fe_final;
      brk_q     <= done_load & brk_final;
      if (done_load) rx_byte_q <= shift_reg;
    end
  end

  assign bus.o_Rx_DV      = rx_dv_q;
  assign bus.o_Rx_Byte    = rx_byte_q;
  assign bus.o_Parity_Err = par_err_q;
  assign bus.o_Frame_Err  = frm_err_q;
  assign bus.o_Break      = brk_q;
  assign bus.o_Busy       = busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 7O2) checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int CPB  = 16;
  localparam int HALF = (CPB - 1) / 2;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
    int         cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   viol = 0;
  int   last_fall = 0;
  logic pdv_a = 1'b0, pdv_b = 1'b0, pdv_c = 1'b0;
  rec_t qa[$], qb[$], qc[$];

  int nd_of[3] = '{8, 8, 7};
  int pm_of[3] = '{0, 2, 1};
  int ns_of[3] = '{1, 1, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_cfg_if #(.DATA_BITS(8)) if_a ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if_c ();

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
    dut_a (.i_Clock(clk), .i_Reset(rst), .bus(if_a));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1))
    dut_b (.i_Clock(clk), .i_Reset(rst), .bus(if_b));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2))
    dut_c (.i_Clock(clk), .i_Reset(rst), .bus(if_c));

  // Capture every DV word; flags outside DV or DV longer than a cycle count as violations.
  always @(negedge clk) begin
    if (if_a.o_Rx_DV === 1'b1)
      qa.push_back('{{1'b0, if_a.o_Rx_Byte}, if_a.o_Parity_Err, if_a.o_Frame_Err, if_a.o_Break, cyc});
    if (if_b.o_Rx_DV === 1'b1)
      qb.push_back('{{1'b0, if_b.o_Rx_Byte}, if_b.o_Parity_Err, if_b.o_Frame_Err, if_b.o_Break, cyc});
    if (if_c.o_Rx_DV === 1'b1)
      qc.push_back('{{2'b00, if_c.o_Rx_Byte}, if_c.o_Parity_Err, if_c.o_Frame_Err, if_c.o_Break, cyc});
    if (if_a.o_Rx_DV === 1'b0 && (if_a.o_Parity_Err | if_a.o_Frame_Err | if_a.o_Break) === 1'b1) viol++;
    if (if_b.o_Rx_DV === 1'b0 && (if_b.o_Parity_Err | if_b.o_Frame_Err | if_b.o_Break) === 1'b1) viol++;
    if (if_c.o_Rx_DV === 1'b0 && (if_c.o_Parity_Err | if_c.o_Frame_Err | if_c.o_Break) === 1'b1) viol++;
    if (if_a.o_Rx_DV === 1'b1 && pdv_a) viol++;
    if (if_b.o_Rx_DV === 1'b1 && pdv_b) viol++;
    if (if_c.o_Rx_DV === 1'b1 && pdv_c) viol++;
    pdv_a = (if_a.o_Rx_DV === 1'b1);
    pdv_b = (if_b.o_Rx_DV === 1'b1);
    pdv_c = (if_c.o_Rx_DV === 1'b1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic good_pbit(input int d, input logic [8:0] data);
    logic [8:0] m;
    int ones;
    m = data & ((9'h1 << nd_of[d]) - 9'h1);
    ones = $countones(m);
    // even: total count of ones incl. parity is even; odd: total is odd
    if (pm_of[d] == 2) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  function automatic rec_t model(input int d, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
    rec_t r;
    logic [8:0] m;
    m = data & ((9'h1 << nd_of[d]) - 9'h1);
    r.data = m;
    r.pe   = (pm_of[d] != 0) && (pbit != good_pbit(d, data));
    r.fe   = (stops[0] == 1'b0) || (ns_of[d] == 2 && stops[1] == 1'b0);
    r.brk  = (m == 9'h0) && (pm_of[d] == 0 || pbit == 1'b0) && (stops[0] == 1'b0);
    r.cyc  = 0;
    return r;
  endfunction

  // 2 synchroniser cycles before the start-detect cycle, then the documented latency
  function automatic int lat(input int d);
    return 2 + (HALF + 1) + (nd_of[d] + (pm_of[d] != 0 ? 1 : 0) + ns_of[d]) * CPB + 1;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic int q_size(input int d);
    case (d)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic pop_rec(input int d, output rec_t r, output bit ok);
    r  = '{default: 0};
    ok = 1'b0;
    for (int i = 0; i < 4 * CPB && q_size(d) == 0; i++) @(negedge clk);
    if (q_size(d) != 0) begin
      ok = 1'b1;
      case (d)
        0:       r = qa.pop_front();
        1:       r = qb.pop_front();
        default: r = qc.pop_front();
      endcase
    end
  endtask

  task automatic set_line(input int d, input logic v);
    case (d)
      0:       if_a.i_Rx_Serial = v;
      1:       if_b.i_Rx_Serial = v;
      default: if_c.i_Rx_Serial = v;
    endcase
  endtask

  // glitch_bit is the frame bit position (0 = start) that gets a one-cycle inversion
  task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops, input int glitch_bit);
    logic v;
    int   np;
    int   nb;
    np = (pm_of[d] != 0) ? 1 : 0;
    nb = 1 + nd_of[d] + np + ns_of[d];
    for (int b = 0; b < nb; b++) begin
      if (b == 0) v = 1'b0;
      else if (b <= nd_of[d]) v = data[b-1];
      else if (np == 1 && b == nd_of[d] + 1) v = pbit;
      else v = stops[b - 1 - nd_of[d] - np];
      if (b == 0) last_fall = cyc;
      for (int c = 0; c < CPB; c++) begin
        set_line(d, (b == glitch_bit && c == 6) ? ~v : v);
        @(negedge clk);
      end
    end
    set_line(d, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_total++; if (if_a.o_Rx_DV !== 1'b0) $display("FAIL reset_dv: got %b want 0", if_a.o_Rx_DV); else n_pass++;
    n_total++; if (if_a.o_Rx_Byte !== 8'h00) $display("FAIL reset_byte: got %h want 00", if_a.o_Rx_Byte); else n_pass++;
    n_total++; if (if_a.o_Parity_Err !== 1'b0) $display("FAIL reset_pe: got %b want 0", if_a.o_Parity_Err); else n_pass++;
    n_total++; if (if_a.o_Frame_Err !== 1'b0) $display("FAIL reset_fe: got %b want 0", if_a.o_Frame_Err); else n_pass++;
    n_total++; if (if_a.o_Break !== 1'b0) $display("FAIL reset_brk: got %b want 0", if_a.o_Break); else n_pass++;
    n_total++; if (if_a.o_Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if_a.o_Busy); else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_total++; if ({if_b.o_Busy, if_c.o_Busy, if_c.o_Rx_Byte} !== 9'h0) $display("FAIL reset_bc: got %h want 000", {if_b.o_Busy, if_c.o_Busy, if_c.o_Rx_Byte}); else n_pass++;
  endtask

  task automatic test_basic;
    rec_t r, e;
    bit   ok;
    e = model(0, 9'h0A5, 1'b0, 2'b11);
    send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
    pop_rec(0, r, ok);
    n_total++; if (!ok) $display("FAIL basic_dv: got no DV want one DV"); else n_pass++;
    n_total++; if (r.data !== e.data) $display("FAIL basic_byte: got %h want %h", r.data, e.data); else n_pass++;
    n_total++; if ({r.pe, r.fe, r.brk} !== 3'b000) $display("FAIL basic_flags: got %b want 000", {r.pe, r.fe, r.brk}); else n_pass++;
    n_total++; if (r.cyc - last_fall !== lat(0)) $display("FAIL basic_latency: got %0d want %0d", r.cyc - last_fall, lat(0)); else n_pass++;
    repeat (2 * CPB) @(negedge clk);
    n_total++; if (q_size(0) !== 0) $display("FAIL basic_single_dv: got %0d extra want 0", q_size(0)); else n_pass++;
    n_total++; if (if_a.o_Busy !== 1'b0) $display("FAIL basic_busy: got %b want 0", if_a.o_Busy); else n_pass++;
  endtask

  task automatic test_parity;
    rec_t r, e;
    bit   ok;
    for (int k = 0; k < 2; k++) begin
      logic pb;
      pb = (k == 0) ? 1'b1 : 1'b0;
      e  = model(1, 9'h037, pb, 2'b11);
      send_frame(1, 9'h037, pb, 2'b11, -1);
      pop_rec(1, r, ok);
      n_total++; if (!ok) $display("FAIL parity_dv[%0d]: got no DV want one DV", k); else n_pass++;
      n_total++; if (r.data !== e.data) $display("FAIL parity_byte[%0d]: got %h want %h", k, r.data, e.data); else n_pass++;
      n_total++; if (r.pe !== e.pe) $display("FAIL parity_err[%0d]: got %b want %b", k, r.pe, e.pe); else n_pass++;
      n_total++; if ({r.fe, r.brk} !== 2'b00) $display("FAIL parity_fe[%0d]: got %b want 00", k, {r.fe, r.brk}); else n_pass++;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic test_break;
    rec_t r, e;
    bit   ok;
    e = model(0, 9'h000, 1'b0, 2'b00);
    set_line(0, 1'b0);
    last_fall = cyc;
    repeat (20 * CPB) @(negedge clk);
    n_total++; if (q_size(0) !== 1) $display("FAIL break_dv_count: got %0d want 1", q_size(0)); else n_pass++;
    n_total++; if (if_a.o_Busy !== 1'b1) $display("FAIL break_wait_busy: got %b want 1", if_a.o_Busy); else n_pass++;
    set_line(0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    n_total++; if (if_a.o_Busy !== 1'b0) $display("FAIL break_release_busy: got %b want 0", if_a.o_Busy); else n_pass++;
    pop_rec(0, r, ok);
    n_total++; if (!ok) $display("FAIL break_dv: got no DV want one DV"); else n_pass++;
    n_total++; if ({r.data, r.pe, r.fe, r.brk} !== {e.data, e.pe, e.fe, e.brk})
      $display("FAIL break_word: got %h/%b%b%b want %h/%b%b%b", r.data, r.pe, r.fe, r.brk, e.data, e.pe, e.fe, e.brk); else n_pass++;
    n_total++; if (r.cyc - last_fall !== lat(0)) $display("FAIL break_latency: got %0d want %0d", r.cyc - last_fall, lat(0)); else n_pass++;
    send_frame(0, 9'h05A, 1'b0, 2'b11, -1);
    pop_rec(0, r, ok);
    n_total++; if (!ok || r.data !== 9'h05A) $display("FAIL break_recover_byte: got %h want 05a", r.data); else n_pass++;
    n_total++; if ({r.pe, r.fe, r.brk} !== 3'b000) $display("FAIL break_recover_flags: got %b want 000", {r.pe, r.fe, r.brk}); else n_pass++;
  endtask

  task automatic test_noise;
    rec_t r;
    bit   ok;
    set_line(0, 1'b0);
    repeat (3) @(negedge clk);
    set_line(0, 1'b1);
    repeat (3 * CPB) @(negedge clk);
    n_total++; if (q_size(0) !== 0) $display("FAIL noise_false_start: got %0d DV want 0", q_size(0)); else n_pass++;
    n_total++; if (if_a.o_Busy !== 1'b0) $display("FAIL noise_busy: got %b want 0", if_a.o_Busy); else n_pass++;
    send_frame(0, 9'h0C3, 1'b0, 2'b11, 3);
    pop_rec(0, r, ok);
    n_total++; if (!ok || r.data !== 9'h0C3) $display("FAIL noise_glitch_byte: got %h want 0c3", r.data); else n_pass++;
    n_total++; if ({r.pe, r.fe, r.brk} !== 3'b000) $display("FAIL noise_glitch_flags: got %b want 000", {r.pe, r.fe, r.brk}); else n_pass++;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    rec_t r, e;
    bit   ok;
    logic pb;
    pb = good_pbit(2, 9'h055);
    e  = model(2, 9'h055, pb, 2'b11);
    send_frame(2, 9'h055, pb, 2'b11, -1);
    send_frame(2, 9'h055, pb, 2'b11, -1);
    for (int k = 0; k < 2; k++) begin
      pop_rec(2, r, ok);
      n_total++; if (!ok) $display("FAIL b2b_dv[%0d]: got no DV want one DV", k); else n_pass++;
      n_total++; if (r.data !== e.data) $display("FAIL b2b_byte[%0d]: got %h want %h", k, r.data, e.data); else n_pass++;
      n_total++; if ({r.pe, r.fe, r.brk} !== 3'b000) $display("FAIL b2b_flags[%0d]: got %b want 000", k, {r.pe, r.fe, r.brk}); else n_pass++;
    end
    e = model(2, 9'h055, pb, 2'b01);
    send_frame(2, 9'h055, pb, 2'b01, -1);
    repeat (CPB) @(negedge clk);
    pop_rec(2, r, ok);
    n_total++; if (!ok || r.data !== e.data) $display("FAIL stop2_byte: got %h want %h", r.data, e.data); else n_pass++;
    n_total++; if ({r.pe, r.fe, r.brk} !== {e.pe, e.fe, e.brk}) $display("FAIL stop2_flags: got %b want %b", {r.pe, r.fe, r.brk}, {e.pe, e.fe, e.brk}); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    rec_t r;
    bit   ok;
    fork
      send_frame(0, 9'h03C, 1'b0, 2'b11, -1);
      begin
        repeat (4 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if ({if_a.o_Rx_DV, if_a.o_Rx_Byte, if_a.o_Parity_Err, if_a.o_Frame_Err, if_a.o_Break, if_a.o_Busy} !== 13'h0)
          $display("FAIL rst_mid_outputs: got dv=%b byte=%h pe=%b fe=%b brk=%b busy=%b want all 0",
                   if_a.o_Rx_DV, if_a.o_Rx_Byte, if_a.o_Parity_Err, if_a.o_Frame_Err, if_a.o_Break, if_a.o_Busy);
        else n_pass++;
      end
    join
    rst = 1'b0;
    repeat (CPB) @(negedge clk);
    n_total++; if (q_size(0) !== 0) $display("FAIL rst_mid_no_dv: got %0d DV want 0", q_size(0)); else n_pass++;
    send_frame(0, 9'h081, 1'b0, 2'b11, -1);
    pop_rec(0, r, ok);
    n_total++; if (!ok || r.data !== 9'h081) $display("FAIL rst_mid_next_byte: got %h want 081", r.data); else n_pass++;
    n_total++; if ({r.pe, r.fe, r.brk} !== 3'b000) $display("FAIL rst_mid_next_flags: got %b want 000", {r.pe, r.fe, r.brk}); else n_pass++;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_random;
    rec_t r, e;
    bit   ok;
    for (int it = 0; it < 20; it++) begin
      int         d, gb;
      logic [8:0] data;
      logic       pb;
      logic [1:0] st;
      d    = $urandom_range(0, 2);
      data = 9'($urandom);
      if ($urandom_range(0, 4) == 0) data = 9'h000;
      pb   = good_pbit(d, data) ^ ($urandom_range(0, 2) == 0);
      st   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      gb   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, nd_of[d])) : -1;
      e    = model(d, data, pb, st);
      send_frame(d, data, pb, st, gb);
      pop_rec(d, r, ok);
      n_total++; if (!ok) $display("FAIL rand_dv[%0d]: got no DV want one DV (dut %0d)", it, d); else n_pass++;
      n_total++; if (r.data !== e.data) $display("FAIL rand_byte[%0d]: got %h want %h", it, r.data, e.data); else n_pass++;
      n_total++; if (r.pe !== e.pe) $display("FAIL rand_pe[%0d]: got %b want %b", it, r.pe, e.pe); else n_pass++;
      n_total++; if (r.fe !== e.fe) $display("FAIL rand_fe[%0d]: got %b want %b", it, r.fe, e.fe); else n_pass++;
      n_total++; if (r.brk !== e.brk) $display("FAIL rand_brk[%0d]: got %b want %b", it, r.brk, e.brk); else n_pass++;
      n_total++; if (r.cyc - last_fall !== lat(d)) $display("FAIL rand_latency[%0d]: got %0d want %0d", it, r.cyc - last_fall, lat(d)); else n_pass++;
      repeat ($urandom_range(1, CPB)) @(negedge clk);
    end
    repeat (2 * CPB) @(negedge clk);
    n_total++; if (q_size(0) + q_size(1) + q_size(2) !== 0) $display("FAIL rand_extra_dv: got %0d want 0", q_size(0) + q_size(1) + q_size(2)); else n_pass++;
  endtask

  task automatic test_integrity;
    n_total++; if (viol !== 0) $display("FAIL dv_flag_integrity: got %0d violations want 0", viol); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    if_a.i_Rx_Serial = 1'b1;
    if_b.i_Rx_Serial = 1'b1;
    if_c.i_Rx_Serial = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_parity;
    test_break;
    test_noise;
    test_back_to_back;
    test_reset_mid_frame;
    test_random;
    test_integrity;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
